// File: rtl/mips_multicycle_control_if.sv
//==============================================================================
// Module      : mips_multicycle_control_if
// Description : Control <-> datapath bundle for the multi-cycle MIPS core.
//               The master side is the control FSM and the slave side is the
//               datapath or an observer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mips_multicycle_control_if;
    // Status flowing from the datapath into control
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    // Controls flowing from control into the datapath
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, state
    );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
//==============================================================================
// Module      : mips_multicycle_control
// Description : Multi-cycle main control FSM for the MIPS core. It steps each
//               instruction through fetch/decode/execute/memory/writeback,
//               drives the alu_control op code and all datapath enables, and
//               stalls on the memory ready handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mips_multicycle_control #(
    parameter logic [3:0] ALU_ADD   = 4'b0000,
    parameter logic [3:0] ALU_SUB   = 4'b0001,
    parameter logic [3:0] ALU_FUNCT = 4'b0010
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    mips_multicycle_control_if.master   bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register; reset aborts any instruction in flight and returns to fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; unreachable codes fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            // IR holds the opcode stable, so it still selects lw vs sw here
            S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // Moore output decode; reset forces every strobe and mux select to zero
    // combinationally, so no write can appear while reset is high
    always_comb begin
        bus.alu_op     = ALU_ADD;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_source  = 2'b00;
        bus.pc_en      = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_en     = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b11;
                    case (bus.opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI:
                                 bus.illegal_op = 1'b0;
                        default: bus.illegal_op = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    bus.mem_write  = 1'b1;
                    bus.i_or_d     = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a  = 1'b1;
                    bus.alu_op     = ALU_SUB;
                    bus.pc_source  = 2'b01;
                    bus.pc_en      = bus.zero;
                    bus.instr_done = 1'b1;
                end
                S_JUMP: begin
                    bus.pc_source  = 2'b10;
                    bus.pc_en      = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_I_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: begin
                    bus.alu_op = ALU_ADD;
                end
            endcase
        end
    end

    assign bus.state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
//==============================================================================
// Module      : tb_mips_multicycle_control
// Description : Self-checking bench for mips_multicycle_control. Each scenario
//               queues per-cycle stimulus together with the expected outputs
//               and compares the DUT cycle by cycle as it drains the queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       rdy;
        outs_t      exp;
    } item_t;

    logic  clk;
    logic  reset;
    int    total;
    int    bad;
    item_t sb[$];

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Reference outputs for a given state, derived from the state table
    function automatic outs_t exp_of(input logic [3:0] st, input logic [5:0] op,
                                     input logic z, input logic rdy);
        outs_t e;
        e = '0;
        e.state = st;
        case (st)
            4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
            4'd1:  begin
                       e.alu_src_b  = 2'b11;
                       e.illegal_op = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                                        op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
                   end
            4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd3:  begin e.mem_read = 1; e.i_or_d = 1; end
            4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
            4'd5:  begin e.mem_write = 1; e.i_or_d = 1; e.instr_done = rdy; end
            4'd6:  begin e.alu_src_a = 1; e.alu_op = 4'b0010; end
            4'd7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
            4'd8:  begin e.alu_src_a = 1; e.alu_op = 4'b0001; e.pc_source = 2'b01;
                         e.pc_en = z; e.instr_done = 1; end
            4'd9:  begin e.pc_source = 2'b10; e.pc_en = 1; e.instr_done = 1; end
            4'd10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd11: begin e.reg_write = 1; e.instr_done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic void push(input logic [5:0] op, input logic z, input logic rdy,
                                 input logic [3:0] st);
        item_t it;
        it.op  = op;
        it.z   = z;
        it.rdy = rdy;
        it.exp = exp_of(st, op, z, rdy);
        sb.push_back(it);
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.state      = bus.state;
        o.alu_op     = bus.alu_op;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.pc_source  = bus.pc_source;
        o.pc_en      = bus.pc_en;
        o.i_or_d     = bus.i_or_d;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.ir_write   = bus.ir_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.reg_write  = bus.reg_write;
        o.instr_done = bus.instr_done;
        o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    task automatic test_reset();
        outs_t obs;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000010;
        bus.zero      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            obs = sample();
            total++;
            if (obs !== outs_t'('0)) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, outs_t'('0));
            end
        end
        @(negedge clk);
        reset = 1'b0;
        push(6'b000010, 0, 1, 4'd0);
        push(6'b000010, 0, 1, 4'd1);
        push(6'b000010, 0, 1, 4'd9);
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            if (total > 3) @(negedge clk);
            bus.opcode = it.op; bus.zero = it.z; bus.mem_ready = it.rdy;
            #1;
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL reset_release: got %h want %h", obs, it.exp);
            end
        end
    endtask

    task automatic test_rtype();
        outs_t obs;
        push(6'b000000, 0, 1, 4'd0);
        push(6'b000000, 0, 1, 4'd1);
        push(6'b000000, 0, 1, 4'd6);
        push(6'b000000, 0, 1, 4'd7);
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            @(negedge clk);
            bus.opcode = it.op; bus.zero = it.z; bus.mem_ready = it.rdy;
            #1;
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL rtype: got %h want %h", obs, it.exp);
            end
        end
    endtask

    task automatic test_lw_stall();
        outs_t obs;
        push(6'b100011, 0, 1, 4'd0);
        push(6'b100011, 0, 1, 4'd1);
        push(6'b100011, 0, 1, 4'd2);
        push(6'b100011, 0, 0, 4'd3);
        push(6'b100011, 0, 0, 4'd3);
        push(6'b100011, 0, 1, 4'd3);
        push(6'b100011, 0, 1, 4'd4);
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            @(negedge clk);
            bus.opcode = it.op; bus.zero = it.z; bus.mem_ready = it.rdy;
            #1;
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL lw_stall: got %h want %h", obs, it.exp);
            end
        end
    endtask

    task automatic test_beq();
        outs_t obs;
        for (int k = 0; k < 2; k++) begin
            logic zz;
            zz = (k == 0);
            push(6'b000100, zz, 1, 4'd0);
            push(6'b000100, zz, 1, 4'd1);
            push(6'b000100, zz, 1, 4'd8);
        end
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            @(negedge clk);
            bus.opcode = it.op; bus.zero = it.z; bus.mem_ready = it.rdy;
            #1;
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL beq(zero=%0b): got %h want %h", it.z, obs, it.exp);
            end
        end
    endtask

    task automatic test_illegal_and_sw();
        outs_t obs;
        push(6'b111111, 0, 1, 4'd0);
        push(6'b111111, 0, 1, 4'd1);
        push(6'b101011, 0, 1, 4'd0);
        push(6'b101011, 0, 1, 4'd1);
        push(6'b101011, 0, 1, 4'd2);
        push(6'b101011, 0, 1, 4'd5);
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            @(negedge clk);
            bus.opcode = it.op; bus.zero = it.z; bus.mem_ready = it.rdy;
            #1;
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL illegal_sw(op=%b): got %h want %h", it.op, obs, it.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        outs_t obs;
        // addi with a fetch stall and mem_ready low in DECODE (ignored there)
        push(6'b001000, 0, 0, 4'd0);
        push(6'b001000, 0, 1, 4'd0);
        push(6'b001000, 0, 0, 4'd1);
        push(6'b001000, 0, 0, 4'd10);
        push(6'b001000, 0, 0, 4'd11);
        push(6'b000010, 0, 1, 4'd0);
        push(6'b000010, 0, 0, 4'd1);
        push(6'b000010, 0, 0, 4'd9);
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            @(negedge clk);
            bus.opcode = it.op; bus.zero = it.z; bus.mem_ready = it.rdy;
            #1;
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL back_to_back(op=%b): got %h want %h", it.op, obs, it.exp);
            end
        end
    endtask

    task automatic test_reset_abort();
        outs_t obs;
        push(6'b101011, 0, 1, 4'd0);
        push(6'b101011, 0, 1, 4'd1);
        push(6'b101011, 0, 1, 4'd2);
        push(6'b101011, 0, 0, 4'd5);
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            @(negedge clk);
            bus.opcode = it.op; bus.zero = it.z; bus.mem_ready = it.rdy;
            #1;
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL reset_abort_pre: got %h want %h", obs, it.exp);
            end
        end
        // Mid-cycle assertion, away from any clock edge
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (bus.mem_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort_mem_write: got %b want 0", bus.mem_write);
        end
        total++;
        if (bus.state !== 4'd0) begin
            bad++;
            $display("FAIL reset_abort_state: got %0d want 0", bus.state);
        end
        @(negedge clk);
        reset = 1'b0;
        push(6'b000010, 0, 1, 4'd0);
        push(6'b000010, 0, 1, 4'd1);
        push(6'b000010, 0, 1, 4'd9);
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            bus.opcode = it.op; bus.zero = it.z; bus.mem_ready = it.rdy;
            #1;
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL reset_abort_recover: got %h want %h", obs, it.exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_illegal_and_sw();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multi-cycle main control FSM for the MIPS core. Sequences each instruction through fetch/decode/execute/memory/writeback, drives the 4-bit op code consumed by alu_control (Op_from_control), and generates all datapath enables. Stalls on a memory ready handshake.

Parameters:
ALU_ADD, 4'b0000, op to alu_control: add (PC+4, address calc, addi)
ALU_SUB, 4'b0001, op to alu_control: subtract (beq compare)
ALU_FUNCT, 4'b0010, op to alu_control: decode from funct field (R-type)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
opcode  input  6  instruction[31:26] from IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
alu_op  output  4  to alu_control Op_from_control
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
pc_en  output  1  PC load = pc_write | (pc_write_cond & zero)
i_or_d  output  1  0=PC address, 1=ALUOut address
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
reg_write  output  1  register file write
instr_done  output  1  one-cycle pulse: instruction retired
illegal_op  output  1  one-cycle pulse: unsupported opcode
state  output  4  current state (debug)

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11. Codes 12-15 unreachable; if entered -> FETCH next cycle.
- Reset: state=FETCH asynchronously; while reset high all strobes (mem_read, mem_write, ir_write, pc_en, reg_write, instr_done, illegal_op) = 0; alu_op=ALU_ADD; all muxes 0.
- Outputs are decoded from state (Moore), except pc_en/ir_write gated by mem_ready and pc_en by zero; any output not listed for a state = 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00; ir_write=pc_en=mem_ready. Stay while !mem_ready; -> DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target to ALUOut). Next by opcode: 100011/101011 -> MEM_ADDR; 000000 -> R_EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> I_EXEC; other -> FETCH with illegal_op=1 this cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; -> MEM_READ (lw) or MEM_WRITE (sw), opcode held stable by IR.
- MEM_READ: mem_read=1, i_or_d=1; stay until mem_ready; -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; stay until mem_ready; instr_done=mem_ready; -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=ALU_FUNCT; -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond, pc_source=01, pc_en=zero, instr_done=1; -> FETCH.
- JUMP: pc_source=10, pc_en=1, instr_done=1; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD; -> I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; -> FETCH.
- Latency with mem_ready tied 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles. Each mem_ready-low cycle in FETCH/MEM_READ/MEM_WRITE adds one cycle.
- mem_ready ignored outside FETCH/MEM_READ/MEM_WRITE. Reset mid-instruction aborts immediately; no write strobe asserted during or after reset release until the FSM re-reaches the state.

Test Plan:
- Reset held 3 cycles, released -> state=0, all strobes 0 during reset; first edge after release with mem_ready=1 -> ir_write=pc_en=1 then state=1.
- R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0; alu_op=0010 in state 6; reg_write=1,reg_dst=1,instr_done=1 in state 7 only.
- lw (100011) with mem_ready low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0 (7 cycles); reg_write=1,mem_to_reg=1 in state 4.
- beq (000100) with zero=1 then repeat with zero=0 -> pc_en=1/pc_source=01/alu_op=0001 in state 8 first run; pc_en=0 second; both 3 cycles.
- Opcode 111111 -> DECODE pulses illegal_op=1, instr_done=0, next state 0; sw (101011) -> mem_write=1,i_or_d=1 in state 5, 4 cycles.
- Reset asserted while in MEM_WRITE with mem_ready=0 -> mem_write drops to 0 asynchronously, state=0.
